// File: rtl/uart_rx_path_cmd.sv
// ---------------------------------------------------------------------------
// uart_rx_path_cmd
//
// UART receiver (8N1, LSB first) followed by a command-frame parser. The host
// sends path-planning commands as four-byte frames:
//
//   HDR_BYTE, start node, end node, TRL_BYTE
//
// Node bytes must lie in 0..63. A good frame updates start_n/end_n and pulses
// cmd_valid. A bad frame pulses frame_err and leaves the node outputs alone.
//
// Optional feature: define UART_RX_PARITY_EN for 8E1 framing. An even-parity
// bit is then expected between the last data bit and the stop bit. A parity
// failure is reported with frame_err at the stop-bit sample and the byte is
// dropped. Without the macro no parity logic exists.
//
// Parameters
//   CLKS_PER_BIT  clk_50 cycles per bit (50 MHz / 115200 = 434)
//   HDR_BYTE      frame header byte ('P')
//   TRL_BYTE      frame trailer byte ('#')
//
// Ports
//   clk_50      in   50 MHz system clock
//   reset       in   synchronous, active-high reset
//   rxin        in   serial line, idle high, asynchronous to clk_50
//   byte_data   out  last byte received with a good stop bit
//   byte_valid  out  1-cycle pulse when byte_data updates
//   start_n     out  latched start node of the last good frame
//   end_n       out  latched end node of the last good frame
//   cmd_valid   out  1-cycle pulse when start_n/end_n update
//   frame_err   out  1-cycle pulse on a bad stop bit, a bad parity bit, a node
//                    byte above 63 or a bad trailer
//   busy        out  high while the receiver is not idle
//
// Handshake: byte_valid and cmd_valid are single-cycle strobes with no ready
// input. The data they qualify (byte_data, start_n/end_n) is already updated
// in the cycle the strobe is high and then holds until the next strobe.
// ---------------------------------------------------------------------------
module uart_rx_path_cmd #(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] HDR_BYTE     = 8'h50,
  parameter logic [7:0] TRL_BYTE     = 8'h23
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       rxin,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic [5:0] start_n,
  output logic [5:0] end_n,
  output logic       cmd_valid,
  output logic       frame_err,
  output logic       busy
);

  // Bit-clock counter width and the two compare points.
  localparam int            CW      = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  // -------------------------------------------------------------------------
  // Receiver state
  // -------------------------------------------------------------------------
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    P_HDR,
    P_START,
    P_END,
    P_TRL
  } p_state_t;

  rx_state_t rx_state;
  rx_state_t rx_next;
  p_state_t  p_state;
  p_state_t  p_next;

  // Synchronizer flops; both preset to the idle line level.
  logic          rx_meta;
  logic          rxs;

  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  // Set after a low stop bit: the receiver parks in STOP until the line
  // returns high so a held-low line is not mistaken for a new start bit.
  logic          stop_hold;
  logic          parity_bad;

  // Receiver control strobes from the next-state logic.
  logic          cnt_clr;
  logic          shift_en;
  logic          byte_ok;
  logic          stop_err;
  logic          hold_set;
  logic          hold_clr;
`ifdef UART_RX_PARITY_EN
  logic          par_en;
  logic          par_bit;
`endif

  // Parser registers and strobes.
  logic [5:0]    temp;
  logic [5:0]    temp2;
  logic          ld_temp;
  logic          ld_temp2;
  logic          ld_cmd;
  logic          p_err;

  // -------------------------------------------------------------------------
  // Input synchronizer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_50) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxin;
      rxs     <= rx_meta;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: data bits plus parity bit must carry an even number of ones.
  assign parity_bad = ^{shift_reg, par_bit};
`else
  assign parity_bad = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Receiver FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_50) begin
    if (reset) begin
      rx_state <= IDLE;
    end else begin
      rx_state <= rx_next;
    end
  end

  // -------------------------------------------------------------------------
  // Receiver FSM: next state and control strobes
  // -------------------------------------------------------------------------
  always_comb begin
    rx_next  = rx_state;
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    byte_ok  = 1'b0;
    stop_err = 1'b0;
    hold_set = 1'b0;
    hold_clr = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en   = 1'b0;
`endif
    case (rx_state)
      IDLE: begin
        if (!rxs) begin
          rx_next = START;
          cnt_clr = 1'b1;
        end
      end
      START: begin
        // Re-check the line near the middle of the start bit; a line that
        // is already high again was a glitch and is dropped silently.
        if (cnt == HALF_M1) begin
          cnt_clr = 1'b1;
          rx_next = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            rx_next = PARITY;
`else
            rx_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == FULL_M1) begin
          cnt_clr = 1'b1;
          par_en  = 1'b1;
          rx_next = STOP;
        end
      end
`endif
      STOP: begin
        if (stop_hold) begin
          if (rxs) begin
            hold_clr = 1'b1;
            rx_next  = IDLE;
          end
        end else if (cnt == FULL_M1) begin
          cnt_clr = 1'b1;
          if (!rxs) begin
            stop_err = 1'b1;
            hold_set = 1'b1;
          end else if (parity_bad) begin
            stop_err = 1'b1;
            rx_next  = IDLE;
          end else begin
            byte_ok = 1'b1;
            rx_next = IDLE;
          end
        end
      end
      default: rx_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Receiver datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_50) begin
    if (reset) begin
      cnt        <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      stop_hold  <= 1'b0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= byte_ok;

      // The bit clock only runs while a byte is in flight and freezes while
      // parked on a held-low stop bit.
      if (cnt_clr) begin
        cnt <= '0;
      end else if (rx_state != IDLE && !stop_hold) begin
        cnt <= cnt + CW'(1);
      end

      if (rx_state == START) begin
        bit_idx <= '0;
      end else if (shift_en) begin
        bit_idx <= bit_idx + 3'd1;
      end

      // LSB arrives first, so shift in from the top.
      if (shift_en) begin
        shift_reg <= {rxs, shift_reg[7:1]};
      end

      if (byte_ok) begin
        byte_data <= shift_reg;
      end

      if (hold_set) begin
        stop_hold <= 1'b1;
      end else if (hold_clr) begin
        stop_hold <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_50) begin
    if (reset) begin
      par_bit <= 1'b0;
    end else if (par_en) begin
      par_bit <= rxs;
    end
  end
`endif

  assign busy = (rx_state != IDLE);

  // -------------------------------------------------------------------------
  // Frame parser FSM: state register and parser datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_50) begin
    if (reset) begin
      p_state   <= P_HDR;
      temp      <= '0;
      temp2     <= '0;
      start_n   <= '0;
      end_n     <= '0;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      p_state   <= p_next;
      cmd_valid <= ld_cmd;
      // Receiver and parser errors never coincide: a parser error follows a
      // good byte, a receiver error replaces one.
      frame_err <= stop_err | p_err;
      if (ld_temp) begin
        temp <= byte_data[5:0];
      end
      if (ld_temp2) begin
        temp2 <= byte_data[5:0];
      end
      // Node outputs change only on a complete, well-formed frame.
      if (ld_cmd) begin
        start_n <= temp;
        end_n   <= temp2;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Frame parser FSM: next state and strobes, advanced only by byte_valid
  // -------------------------------------------------------------------------
  always_comb begin
    p_next   = p_state;
    ld_temp  = 1'b0;
    ld_temp2 = 1'b0;
    ld_cmd   = 1'b0;
    p_err    = 1'b0;
    if (byte_valid) begin
      case (p_state)
        P_HDR: begin
          // Anything other than the header is line noise between frames.
          if (byte_data == HDR_BYTE) begin
            p_next = P_START;
          end
        end
        P_START: begin
          // A header value here is just an out-of-range node; no resync.
          if (byte_data[7:6] == 2'b00) begin
            ld_temp = 1'b1;
            p_next  = P_END;
          end else begin
            p_err  = 1'b1;
            p_next = P_HDR;
          end
        end
        P_END: begin
          if (byte_data[7:6] == 2'b00) begin
            ld_temp2 = 1'b1;
            p_next   = P_TRL;
          end else begin
            p_err  = 1'b1;
            p_next = P_HDR;
          end
        end
        P_TRL: begin
          if (byte_data == TRL_BYTE) begin
            ld_cmd = 1'b1;
          end else begin
            p_err = 1'b1;
          end
          p_next = P_HDR;
        end
        default: p_next = P_HDR;
      endcase
    end
    // A byte lost on the wire breaks the frame it belonged to.
    if (stop_err) begin
      p_next = P_HDR;
    end
  end

endmodule

// File: tb/tb_uart_rx_path_cmd.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_path_cmd
//
// Drives serial frames into uart_rx_path_cmd and compares the received
// bytes, commands, error pulses and node outputs with a byte-level model of
// the command protocol. A short bit period keeps the run brief.
// Define UART_RX_PARITY_EN on both files to exercise the 8E1 build.
// ---------------------------------------------------------------------------
module tb_uart_rx_path_cmd;

  localparam int         CPB = 32;
  localparam logic [7:0] HDR = 8'h50;
  localparam logic [7:0] TRL = 8'h23;
`ifdef UART_RX_PARITY_EN
  localparam int         LAT_NOM = CPB / 2 + 10 * CPB;
`else
  localparam int         LAT_NOM = CPB / 2 + 9 * CPB;
`endif

  // -------------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------------
  logic       clk_50 = 1'b0;
  logic       reset  = 1'b1;
  logic       rxin   = 1'b1;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic [5:0] start_n;
  logic [5:0] end_n;
  logic       cmd_valid;
  logic       frame_err;
  logic       busy;

  always #10 clk_50 = ~clk_50;

  uart_rx_path_cmd #(
    .CLKS_PER_BIT (CPB),
    .HDR_BYTE     (HDR),
    .TRL_BYTE     (TRL)
  ) dut (
    .clk_50     (clk_50),
    .reset      (reset),
    .rxin       (rxin),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .start_n    (start_n),
    .end_n      (end_n),
    .cmd_valid  (cmd_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  int cyc = 0;
  always @(posedge clk_50) cyc <= cyc + 1;

  // -------------------------------------------------------------------------
  // Scoreboard state
  // -------------------------------------------------------------------------
  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [11:0] exp_cmd_q[$];
  logic [11:0] got_cmd_q[$];
  int          exp_err = 0;
  int          got_err = 0;
  int          bv_cyc  = 0;
  int          tx_start_cyc = 0;

  // Protocol model: position inside the current frame plus latched nodes.
  int          m_pos   = 0;
  logic [5:0]  m_s     = '0;
  logic [5:0]  m_e     = '0;
  logic [5:0]  m_start = '0;
  logic [5:0]  m_end   = '0;

  // Monitor samples on the falling edge, away from DUT updates.
  always @(negedge clk_50) begin
    if (byte_valid) begin
      got_q.push_back(byte_data);
      bv_cyc = cyc;
    end
    if (cmd_valid) got_cmd_q.push_back({start_n, end_n});
    if (frame_err) got_err++;
  end

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Check and model tasks
  // -------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    exp_q.push_back(b);
    case (m_pos)
      0: if (b == HDR) m_pos = 1;
      1: begin
        if (b < 8'd64) begin m_s = b[5:0]; m_pos = 2; end
        else begin exp_err++; m_pos = 0; end
      end
      2: begin
        if (b < 8'd64) begin m_e = b[5:0]; m_pos = 3; end
        else begin exp_err++; m_pos = 0; end
      end
      default: begin
        if (b == TRL) begin
          m_start = m_s;
          m_end   = m_e;
          exp_cmd_q.push_back({m_s, m_e});
        end else begin
          exp_err++;
        end
        m_pos = 0;
      end
    endcase
  endtask

  task automatic model_reset();
    m_pos   = 0;
    m_start = '0;
    m_end   = '0;
  endtask

  task automatic check_stream(input string tag);
    int n;
    repeat (4) @(negedge clk_50);
    check({tag, " byte_cnt"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, " byte"}, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
    check({tag, " cmd_cnt"}, got_cmd_q.size(), exp_cmd_q.size());
    n = (got_cmd_q.size() < exp_cmd_q.size()) ? got_cmd_q.size() : exp_cmd_q.size();
    for (int i = 0; i < n; i++) check({tag, " cmd"}, 32'(got_cmd_q[i]), 32'(exp_cmd_q[i]));
    got_cmd_q.delete();
    exp_cmd_q.delete();
    check({tag, " err_cnt"}, got_err, exp_err);
    check({tag, " start_n"}, 32'(start_n), 32'(m_start));
    check({tag, " end_n"}, 32'(end_n), 32'(m_end));
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks (line changes on the falling edge)
  // -------------------------------------------------------------------------
  task automatic drive_line(input logic v, input int n);
    rxin = v;
    repeat (n) @(negedge clk_50);
  endtask

  task automatic send_byte(input logic [7:0] b, input int stop_low, input int gap);
    tx_start_cyc = cyc;
    drive_line(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_line(b[i], CPB);
`ifdef UART_RX_PARITY_EN
    drive_line(^b, CPB);
`endif
    if (stop_low > 0) drive_line(1'b0, CPB * stop_low);
    drive_line(1'b1, CPB * (1 + gap));
  endtask

  task automatic send_model(input logic [7:0] b, input int gap);
    model_byte(b);
    send_byte(b, 0, gap);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_bad_parity(input logic [7:0] b);
    drive_line(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_line(b[i], CPB);
    drive_line(~(^b), CPB);
    drive_line(1'b1, 2 * CPB);
  endtask
`endif

  // -------------------------------------------------------------------------
  // Directed and random sequence
  // -------------------------------------------------------------------------
  initial begin
    int         lat;
    int         kind;
    logic [7:0] s;
    logic [7:0] e;
    logic [7:0] t;
    logic [7:0] noise;

    // Reset state
    reset = 1'b1;
    rxin  = 1'b1;
    repeat (5) @(negedge clk_50);
    check("rst byte_data", 32'(byte_data), 32'h0);
    check("rst byte_valid", 32'(byte_valid), 32'h0);
    check("rst start_n", 32'(start_n), 32'h0);
    check("rst end_n", 32'(end_n), 32'h0);
    check("rst cmd_valid", 32'(cmd_valid), 32'h0);
    check("rst frame_err", 32'(frame_err), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    reset = 1'b0;
    repeat (5) @(negedge clk_50);

    // Single byte 0xA5 and its latency
    send_model(8'hA5, 1);
    lat = bv_cyc - tx_start_cyc - LAT_NOM;
    check("a5 latency_in_window", 32'(lat >= -3 && lat <= 3), 32'h1);
    check("a5 byte_data", 32'(byte_data), 32'hA5);
    check("a5 busy_after", 32'(busy), 32'h0);
    check_stream("a5");

    // Back-to-back good frame
    send_model(HDR, 0);
    send_model(8'h05, 0);
    send_model(8'h2A, 0);
    send_model(TRL, 0);
    check_stream("frame1");
    check("frame1 start_n", 32'(start_n), 32'd5);
    check("frame1 end_n", 32'(end_n), 32'd42);

    // Bad start node, then a good frame
    send_model(HDR, 0);
    send_model(8'h45, 0);
    send_model(8'h10, 0);
    send_model(TRL, 1);
    check_stream("badnode");
    check("badnode start_n_kept", 32'(start_n), 32'd5);
    check("badnode end_n_kept", 32'(end_n), 32'd42);
    send_model(HDR, 0);
    send_model(8'h01, 0);
    send_model(8'h02, 0);
    send_model(TRL, 1);
    check_stream("frame2");
    check("frame2 start_n", 32'(start_n), 32'd1);
    check("frame2 end_n", 32'(end_n), 32'd2);

    // Stop bit held low for two bit times, then a good byte
    send_byte(8'h33, 2, 2);
    exp_err++;
    m_pos = 0;
    check_stream("stoplow");
    send_model(HDR, 1);
    check_stream("after_stoplow");

    // Short low glitch while idle
    drive_line(1'b0, CPB / 4);
    drive_line(1'b1, 2 * CPB);
    check("glitch busy", 32'(busy), 32'h0);
    check_stream("glitch");

    // Reset in the third data bit of a header byte, parser mid-frame
    drive_line(1'b0, CPB);
    drive_line(HDR[0], CPB);
    drive_line(HDR[1], CPB);
    drive_line(HDR[2], CPB / 2);
    check("midbyte busy", 32'(busy), 32'h1);
    reset = 1'b1;
    rxin  = 1'b1;
    repeat (3) @(negedge clk_50);
    check("midrst busy", 32'(busy), 32'h0);
    check("midrst byte_data", 32'(byte_data), 32'h0);
    check("midrst start_n", 32'(start_n), 32'h0);
    check("midrst end_n", 32'(end_n), 32'h0);
    reset = 1'b0;
    model_reset();
    repeat (4) @(negedge clk_50);
    send_model(HDR, 0);
    send_model(8'h07, 0);
    send_model(8'h08, 0);
    send_model(TRL, 1);
    check_stream("frame3");
    check("frame3 start_n", 32'(start_n), 32'd7);
    check("frame3 end_n", 32'(end_n), 32'd8);

    // Random frames: good, bad start, bad end, bad trailer, with noise
    for (int f = 0; f < 12; f++) begin
      kind = $urandom_range(0, 4);
      if ($urandom_range(0, 3) == 0) begin
        noise = 8'($urandom_range(0, 255));
        if (noise == HDR) noise = 8'h00;
        send_model(noise, $urandom_range(0, 1));
      end
      s = 8'($urandom_range(0, 63));
      e = 8'($urandom_range(0, 63));
      t = TRL;
      if (kind == 2) s = 8'($urandom_range(64, 255));
      if (kind == 3) e = 8'($urandom_range(64, 255));
      if (kind == 4) begin
        t = 8'($urandom_range(0, 255));
        if (t == TRL) t = t ^ 8'h01;
      end
      send_model(HDR, $urandom_range(0, 1));
      send_model(s, $urandom_range(0, 1));
      send_model(e, $urandom_range(0, 1));
      send_model(t, 1);
      check_stream("rand");
    end

`ifdef UART_RX_PARITY_EN
    // Byte 0x01 with parity bit 0 fails even parity
    send_bad_parity(8'h01);
    exp_err++;
    m_pos = 0;
    check_stream("parity");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
